apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: the number of consecutive ACCESS cycles with PREADY=0 after which the transfer is aborted; 0 disables the timeout.
REQ-002 SHALL have one clock and an asynchronous active-high reset; all outputs are registered.
REQ-003 PCLK  in  1  fabric clock; all logic is rising-edge.
REQ-004 PRESET  in  1  asynchronous active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted on any cycle where cmd_valid=1 and cmd_ready=1.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  32  target address.
REQ-009 cmd_wdata  in  32  write data; ignored for reads.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed on any cycle where rsp_valid=1 and rsp_ready=1.
REQ-012 rsp_rdata  out  32  read data; 0 for writes and timeouts.
REQ-013 rsp_err  out  1  PSLVERR was sampled high, or a timeout occurred.
REQ-014 rsp_timeout  out  1  the transfer was aborted by the timeout.
REQ-015 PSEL, PENABLE, PWRITE  out  1 each  APB3 master controls.
REQ-016 PADDR, PWDATA  out  32 each  APB3 address and write data.
REQ-017 PREADY, PSLVERR  in  1 each; PRDATA  in  32  APB3 slave returns.

Function
REQ-018 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-019 IDLE behaviour:
- cmd_ready=1.
- On a command handshake, capture cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA (PWDATA=0 for reads) and go to SETUP.
REQ-020 SETUP behaviour:
- Lasts exactly one cycle: PSEL=1, PENABLE=0, cmd_ready=0.
- Then go to ACCESS.
REQ-021 ACCESS behaviour:
- PSEL=1, PENABLE=1.
- Remains in ACCESS while PREADY=0.
- On the first cycle with PREADY=1, capture rsp_rdata (PRDATA for reads, 0 for writes) and rsp_err=PSLVERR, set rsp_timeout=0, and go to RESP.
REQ-022 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP through the final ACCESS cycle; outside a transfer they hold their last values.
REQ-023 RESP behaviour:
- PSEL=0, PENABLE=0, rsp_valid=1.
- rsp_* held stable until the rsp_ready handshake, then go to IDLE.
- rsp_valid deasserts the cycle after the handshake.
REQ-024 Minimum latency SHALL be:
- Command handshake to first SETUP cycle: 1 cycle.
- Zero-wait transfer: rsp_valid asserts 3 cycles after the command handshake.
- Back-to-back commands: one IDLE cycle between transfers.
REQ-025 Timeout (TIMEOUT>0):
- An 8-bit wait counter clears on SETUP entry and increments on each ACCESS cycle with PREADY=0.
- When the counter reaches TIMEOUT, deassert PSEL/PENABLE next cycle, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, and go to RESP.
REQ-026 PREADY=1 on the same cycle the counter reaches TIMEOUT SHALL complete normally (no timeout).
REQ-027 cmd_valid SHALL be ignored outside IDLE; no command queueing.
REQ-028 PREADY, PRDATA and PSLVERR SHALL be ignored outside ACCESS.
REQ-029 PENABLE=1 SHALL never occur without PSEL=1, and never on the first cycle PSEL asserts.

Reset
REQ-030 While PRESET=1 the block SHALL be in IDLE with:
- PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0.
- cmd_ready=0.
- rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, wait counter=0.
REQ-031 cmd_ready SHALL assert on the first PCLK edge after PRESET deasserts.
REQ-032 Reset mid-transfer (SETUP, ACCESS or RESP) SHALL immediately drop PSEL/PENABLE/rsp_valid with no response delivered; the aborted command is lost.

Verification
REQ-033 Zero-wait write:
- Stimulus: write addr 0x40050000, data 0x000001FF; slave PREADY=1; rsp_ready=1.
- Response: PSEL one cycle with PENABLE=0, then one cycle with both=1; PADDR/PWDATA stable; rsp_valid 3 cycles after handshake; rsp_err=0, rsp_rdata=0.
REQ-034 Read with waits:
- Stimulus: read addr 0x40050004; PREADY low 3 ACCESS cycles; PRDATA=0xA5A5_0003.
- Response: ACCESS lasts 4 cycles; rsp_rdata=0xA5A50003; rsp_err=0.
REQ-035 Slave error:
- Stimulus: write with PSLVERR=1, PREADY=1.
- Response: rsp_err=1, rsp_timeout=0.
REQ-036 Timeout, TIMEOUT=4:
- Stimulus: PREADY held 0.
- Response: exactly 4 ACCESS cycles, then PSEL=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Repeat with PREADY=1 on the 4th wait cycle: normal completion.
REQ-037 Backpressure and back-to-back:
- Stimulus: rsp_ready=0 for 5 cycles, second command already valid.
- Response: rsp_* stable, cmd_ready=0 throughout; second SETUP starts 2 cycles after the rsp handshake.
REQ-038 Reset mid-ACCESS:
- Stimulus: assert PRESET in ACCESS.
- Response: all outputs 0 asynchronously; no rsp_valid; cmd_ready=1 one edge after release.

Source files
------------

// File: rtl/apb_master_if.sv
// apb_master_if: command/response handshake and APB3 bus signals of apb_master.
interface apb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PSLVERR, PRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PSLVERR, PRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3 master with wait-state timeout.
module apb_master #(
    parameter int TIMEOUT = 16
) (
    input logic          PCLK,
    input logic          PRESET,
    apb_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_cmd_ready, r_psel, r_penable, r_pwrite;
    logic [31:0] r_paddr, r_pwdata;
    logic        r_rsp_valid, r_rsp_err, r_rsp_timeout;
    logic [31:0] r_rsp_rdata;
    logic [7:0]  r_wait;
    logic        w_take, w_tmo, w_fin;

    assign w_take = r_state == IDLE && bus.cmd_valid && r_cmd_ready;
    // Abort on the edge where the counter would reach TIMEOUT, so exactly TIMEOUT ACCESS cycles occur
    assign w_tmo  = TIMEOUT != 0 && r_state == ACCESS && !bus.PREADY &&
                    (32'(r_wait) + 32'd1 == 32'(TIMEOUT));
    assign w_fin  = r_state == ACCESS && (bus.PREADY || w_tmo);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_take ? SETUP : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = w_fin ? RESP : ACCESS;
            RESP:    w_next = bus.rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
            r_wait        <= '0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= w_next == IDLE;
            r_psel      <= w_next == SETUP || w_next == ACCESS;
            r_penable   <= w_next == ACCESS;
            r_rsp_valid <= w_next == RESP;
            if (w_take) begin
                r_pwrite <= bus.cmd_write;
                r_paddr  <= bus.cmd_addr;
                r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
                r_wait   <= '0;
            end else if (r_state == ACCESS && !bus.PREADY) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_fin) begin
                r_rsp_rdata   <= (bus.PREADY && !r_pwrite) ? bus.PRDATA : '0;
                r_rsp_err     <= bus.PREADY ? bus.PSLVERR : 1'b1;
                r_rsp_timeout <= !bus.PREADY;
            end
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven and randomized transfers against an APB slave model and response reference.
module tb_apb_master;
    localparam int TO = 4;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        int          rsp_delay;
        int          exp_acc;
        logic        exp_to;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    apb_master_if bus();
    apb_master #(.TIMEOUT(TO)) dut (.PCLK(clk), .PRESET(rst), .bus(bus.master));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"}, 32'(bus.PSEL), 0);
        chk({tag, "_penable"}, 32'(bus.PENABLE), 0);
        chk({tag, "_pwrite"}, 32'(bus.PWRITE), 0);
        chk({tag, "_paddr"}, bus.PADDR, 0);
        chk({tag, "_pwdata"}, bus.PWDATA, 0);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
        chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    endtask

    // Reference: a slave that stalls `waits` cycles is cut off after TO stalled cycles
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_to    = v.waits >= TO;
        r.exp_acc   = r.exp_to ? TO : v.waits + 1;
        r.exp_err   = r.exp_to || v.slverr;
        r.exp_rdata = (r.exp_to || v.write) ? 32'h0 : v.prdata;
        return r;
    endfunction

    task automatic xfer(input vec_t v, input bit has_nxt, input vec_t nv);
        int          guard, lat, acc;
        bit          stab, hold;
        logic [31:0] rd;
        logic        re, rt;
        bus.cmd_write = v.write;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_valid = 1'b1;
        guard = 0;
        while (!bus.cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_wait", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        bus.cmd_valid = has_nxt;
        if (has_nxt) begin
            bus.cmd_write = nv.write;
            bus.cmd_addr  = nv.addr;
            bus.cmd_wdata = nv.wdata;
        end
        bus.PREADY  = 1'($urandom_range(0, 1));
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA  = $urandom;
        chk("setup_psel_penable", 32'({bus.PSEL, bus.PENABLE}), 32'b10);
        stab = bus.PADDR == v.addr && bus.PWRITE == v.write && bus.PWDATA == (v.write ? v.wdata : 32'h0);
        lat  = 1;
        acc  = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.PSEL && bus.PENABLE) begin
                acc++;
                stab &= bus.PADDR == v.addr && bus.PWRITE == v.write &&
                        bus.PWDATA == (v.write ? v.wdata : 32'h0);
                bus.PREADY  = acc == v.waits + 1;
                bus.PRDATA  = bus.PREADY ? v.prdata : $urandom;
                bus.PSLVERR = bus.PREADY ? v.slverr : 1'($urandom_range(0, 1));
            end else begin
                bus.PREADY  = 1'($urandom_range(0, 1));
                bus.PSLVERR = 1'($urandom_range(0, 1));
                bus.PRDATA  = $urandom;
            end
        end
        chk("rsp_latency", 32'(lat), 32'(2 + v.exp_acc));
        chk("access_cycles", 32'(acc), 32'(v.exp_acc));
        chk("addr_data_stable", 32'(stab), 1);
        chk("resp_psel_penable", 32'({bus.PSEL, bus.PENABLE}), 0);
        chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(v.exp_to));
        rd = bus.rsp_rdata;
        re = bus.rsp_err;
        rt = bus.rsp_timeout;
        bus.rsp_ready = v.rsp_delay == 0;
        hold = 1'b1;
        for (int k = 0; k < v.rsp_delay; k++) begin
            @(negedge clk);
            hold &= bus.rsp_valid && bus.rsp_rdata == rd && bus.rsp_err == re &&
                    bus.rsp_timeout == rt && !bus.cmd_ready && !bus.PSEL && !bus.PENABLE;
            if (k == v.rsp_delay - 1) bus.rsp_ready = 1'b1;
        end
        if (v.rsp_delay > 0) chk("rsp_backpressure_hold", 32'(hold), 1);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("post_rsp_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("post_rsp_psel", 32'(bus.PSEL), 0);
    endtask

    vec_t tbl[7];
    vec_t rnd[40];
    vec_t none;

    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
        bus.rsp_ready = 0; bus.PREADY = 0; bus.PSLVERR = 0; bus.PRDATA = 0;
        none = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        //        wr    addr          wdata         waits err prdata        dly acc to err rdata
        tbl[0] = '{1'b1, 32'h4005_0000, 32'h0000_01FF, 0, 1'b0, 32'hDEAD_BEEF, 0, 1, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h4005_0004, 32'h7777_7777, 3, 1'b0, 32'hA5A5_0003, 0, 4, 1'b0, 1'b0, 32'hA5A5_0003};
        tbl[2] = '{1'b1, 32'h4005_0008, 32'h1234_5678, 0, 1'b1, 32'h5555_5555, 1, 1, 1'b0, 1'b1, 32'h0};
        tbl[3] = '{1'b0, 32'h4005_000C, 32'h0,         4, 1'b0, 32'h1111_2222, 0, 4, 1'b1, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 32'h4005_0010, 32'h0,         2, 1'b1, 32'hCAFE_F00D, 2, 3, 1'b0, 1'b1, 32'hCAFE_F00D};
        tbl[5] = '{1'b1, 32'h4005_0014, 32'hFFFF_0000, 10, 1'b0, 32'h3333_4444, 5, 4, 1'b1, 1'b1, 32'h0};
        tbl[6] = '{1'b0, 32'h4005_0018, 32'h9999_9999, 0, 1'b0, 32'h0BAD_F00D, 5, 1, 1'b0, 1'b0, 32'h0BAD_F00D};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        chk("cmd_ready_before_edge", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        chk("cmd_ready_after_release", 32'(bus.cmd_ready), 1);

        for (int i = 0; i < 7; i++) xfer(tbl[i], i < 6, i < 6 ? tbl[i + 1] : none);

        // Reset while the slave is stalling in ACCESS
        bus.cmd_write = 1'b0; bus.cmd_addr = 32'h4005_0020; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        @(negedge clk);
        chk("mid_access_psel_penable", 32'({bus.PSEL, bus.PENABLE}), 32'b11);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        repeat (2) @(negedge clk);
        chk("reset_no_rsp", 32'(bus.rsp_valid), 0);
        rst = 1'b0;
        chk("rerelease_cmd_ready_before_edge", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        chk("rerelease_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rerelease_rsp_valid", 32'(bus.rsp_valid), 0);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.write     = 1'($urandom_range(0, 1));
            v.addr      = $urandom;
            v.wdata     = $urandom;
            v.waits     = $urandom_range(0, 6);
            v.slverr    = $urandom_range(0, 3) == 0;
            v.prdata    = $urandom;
            v.rsp_delay = $urandom_range(0, 3);
            rnd[i] = model(v);
        end
        for (int i = 0; i < 40; i++) xfer(rnd[i], i < 39 && $urandom_range(0, 1) == 1, i < 39 ? rnd[i + 1] : none);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
